// File: rtl/yuu_common_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// yuu_common_pkg : shared arbiter types and the masked round-robin pick helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package yuu_common_pkg;

  typedef logic yuu_bool_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } yuu_arb_state_e;

  localparam int unsigned YUU_PICK_MAX = 16;
  localparam int unsigned YUU_STAT_W   = 16;

  typedef struct packed {
    yuu_bool_t  vld;
    logic [3:0] idx;
  } yuu_pick_t;

  // First set, unmasked bit scanning ptr, ptr+1, ... modulo n (n <= 16, ptr < n).
  function automatic yuu_pick_t yuu_rr_pick(input logic [15:0] req,
                                            input logic [3:0]  ptr,
                                            input logic [15:0] mask,
                                            input int unsigned n);
    yuu_pick_t  res;
    logic [4:0] j;
    res = '0;
    for (int unsigned i = 0; i < YUU_PICK_MAX; i++) begin
      j = {1'b0, ptr} + 5'(i);
      if (j >= 5'(n)) j = j - 5'(n);
      if ((i < n) && !res.vld && req[j[3:0]] && !mask[j[3:0]]) begin
        res.vld = 1'b1;
        res.idx = j[3:0];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/yuu_common_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// yuu_common_rr_arbiter_if : request/grant bundle between requesters and arbiter
// Rev 1.0 | stats signals present only with YUU_COMMON_ARB_STAT_EN
// ---------------------------------------------------------------------------
`default_nettype none

interface yuu_common_rr_arbiter_if #(
  parameter int REQ_NUM = 4,
  parameter int ID_W    = $clog2(REQ_NUM)
);
  logic [REQ_NUM-1:0] req;
  logic [REQ_NUM-1:0] done;
  logic [REQ_NUM-1:0] gnt;
  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic               preempt;
`ifdef YUU_COMMON_ARB_STAT_EN
  logic [REQ_NUM-1:0][15:0] grant_cnt;
  logic [15:0]              preempt_cnt;

  modport master (output req, done,
                  input  gnt, gnt_vld, gnt_id, preempt, grant_cnt, preempt_cnt);
  modport slave  (input  req, done,
                  output gnt, gnt_vld, gnt_id, preempt, grant_cnt, preempt_cnt);
`else
  modport master (output req, done,
                  input  gnt, gnt_vld, gnt_id, preempt);
  modport slave  (input  req, done,
                  output gnt, gnt_vld, gnt_id, preempt);
`endif
endinterface

`default_nettype wire

// File: rtl/yuu_common_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// yuu_common_rr_pick : combinational masked round-robin picker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module yuu_common_rr_pick
  import yuu_common_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int ID_W    = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic [REQ_NUM-1:0] mask_i,
  output logic               vld_o,
  output logic [ID_W-1:0]    idx_o
);

  logic [15:0] req_ext;
  logic [15:0] mask_ext;
  logic [3:0]  ptr_ext;
  yuu_pick_t   pick;
  logic        unused_idx_hi;

  always_comb begin
    req_ext               = '0;
    mask_ext              = '0;
    ptr_ext               = '0;
    req_ext[REQ_NUM-1:0]  = req_i;
    mask_ext[REQ_NUM-1:0] = mask_i;
    ptr_ext[ID_W-1:0]     = ptr_i;
    pick                  = yuu_rr_pick(req_ext, ptr_ext, mask_ext, REQ_NUM);
  end

  assign vld_o         = pick.vld;
  assign idx_o         = pick.idx[ID_W-1:0];
  assign unused_idx_hi = ^pick.idx;

endmodule

`default_nettype wire

// File: rtl/yuu_common_rr_arbiter.sv
// ---------------------------------------------------------------------------
// yuu_common_rr_arbiter : round-robin arbiter, registered one-hot grant, hold limit
// Rev 1.0 | optional grant/preempt counters: YUU_COMMON_ARB_STAT_EN
// ---------------------------------------------------------------------------
`default_nettype none

module yuu_common_rr_arbiter
  import yuu_common_pkg::*;
#(
  parameter int REQ_NUM  = 4,
  parameter int ID_W     = $clog2(REQ_NUM),
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  yuu_common_rr_arbiter_if.slave  arb_if
);

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);

  yuu_arb_state_e     state_q, state_d;
  logic [REQ_NUM-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               preempt_q, preempt_d;

  yuu_bool_t          own_req, own_done, others, forced, release_c;
  logic               pick_vld;
  logic [ID_W-1:0]    pick_idx, pick_nxt;

  // Masking with the current grant excludes the owner during re-arbitration; in IDLE gnt_q is 0.
  yuu_common_rr_pick #(.REQ_NUM(REQ_NUM), .ID_W(ID_W)) u_pick (
    .req_i  (arb_if.req),
    .ptr_i  (ptr_q),
    .mask_i (gnt_q),
    .vld_o  (pick_vld),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    own_req   = |(arb_if.req & gnt_q);
    own_done  = |(arb_if.done & gnt_q);
    others    = |(arb_if.req & ~gnt_q);
    // >= so that a saturated counter still forces release once someone else asks.
    forced    = HOLD_EN && (state_q == GRANT) && (hold_q >= HOLD_LAST) && others;
    release_c = (state_q == GRANT) && (!own_req || own_done || forced);
    pick_nxt  = (pick_idx == ID_W'(REQ_NUM - 1)) ? '0 : pick_idx + 1'b1;

    if ((state_q == IDLE) || release_c) begin
      if (pick_vld) begin
        state_d   = GRANT;
        gnt_d     = REQ_NUM'(1) << pick_idx;
        owner_d   = pick_idx;
        ptr_d     = pick_nxt;
        hold_d    = '0;
        preempt_d = forced && own_req && !own_done;
      end else if (own_req && own_done) begin
        hold_d    = '0;
      end else begin
        state_d   = IDLE;
        gnt_d     = '0;
        owner_d   = '0;
        hold_d    = '0;
      end
    end else begin
      hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign arb_if.gnt     = gnt_q;
  assign arb_if.gnt_vld = (state_q == GRANT);
  assign arb_if.gnt_id  = owner_q;
  assign arb_if.preempt = preempt_q;

`ifdef YUU_COMMON_ARB_STAT_EN
  logic [REQ_NUM-1:0][YUU_STAT_W-1:0] grant_cnt_q;
  logic [YUU_STAT_W-1:0]              preempt_cnt_q;
  yuu_bool_t                          issue;

  // A grant is issued whenever the next state owns the resource after an arbitration point.
  assign issue = (state_d == GRANT) && ((state_q == IDLE) || release_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q   <= '0;
      preempt_cnt_q <= '0;
    end else begin
      if (issue)     grant_cnt_q[owner_d] <= grant_cnt_q[owner_d] + 1'b1;
      if (preempt_d) preempt_cnt_q        <= preempt_cnt_q + 1'b1;
    end
  end

  assign arb_if.grant_cnt   = grant_cnt_q;
  assign arb_if.preempt_cnt = preempt_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_yuu_common_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_yuu_common_rr_arbiter : directed scenarios plus random traffic vs. a queue-free owner model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_yuu_common_rr_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  yuu_common_rr_arbiter_if #(.REQ_NUM(N), .ID_W(2)) arb_if ();

  yuu_common_rr_arbiter #(
    .REQ_NUM  (N),
    .ID_W     (2),
    .MAX_HOLD (MAXH),
    .CNT_W    (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (arb_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model state: owner index (-1 = none), scan start, cycles the current grant has been visible.
  int          m_own = -1;
  int          m_ptr = 0;
  int          m_age = 0;
  bit          m_pre = 1'b0;
  logic [15:0] m_gcnt [N];
  logic [15:0] m_pcnt = '0;

  function automatic int scan(input logic [3:0] r, input int from, input int excl);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (from + i) % N;
      if (r[j] && (j != excl)) return j;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    m_own = w;
    m_ptr = (w + 1) % N;
    m_age = 1;
    m_gcnt[w] = m_gcnt[w] + 16'd1;
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_ptr  = 0;
    m_age  = 0;
    m_pre  = 1'b0;
    m_pcnt = '0;
    for (int i = 0; i < N; i++) m_gcnt[i] = '0;
  endtask

  task automatic model_step();
    logic [3:0] r, d;
    int         nxt;
    bit         fr, orq, odn;
    r     = arb_if.req;
    d     = arb_if.done;
    m_pre = 1'b0;
    if (m_own < 0) begin
      nxt = scan(r, m_ptr, -1);
      if (nxt >= 0) take(nxt);
    end else begin
      orq = r[m_own];
      odn = d[m_own];
      fr  = (MAXH > 0) && (m_age >= MAXH) && ((r & ~(4'b0001 << m_own)) != 4'b0000);
      if (!orq || odn || fr) begin
        nxt = scan(r, m_ptr, m_own);
        if (nxt >= 0) begin
          m_pre = fr && orq && !odn;
          if (m_pre) m_pcnt = m_pcnt + 16'd1;
          take(nxt);
        end else if (orq && odn) begin
          m_age = 1;
          m_gcnt[m_own] = m_gcnt[m_own] + 16'd1;
        end else begin
          m_own = -1;
          m_age = 0;
        end
      end else begin
        m_age++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    logic [3:0]  eg;
    logic [1:0]  eid;
    logic [63:0] ecnt;
    forever begin
      @(negedge clk);
      eg  = (m_own < 0) ? 4'b0000 : 4'(4'b0001 << m_own);
      eid = (m_own < 0) ? 2'd0 : 2'(m_own);
      chk("gnt",     64'(arb_if.gnt),     64'(eg));
      chk("gnt_vld", 64'(arb_if.gnt_vld), 64'(m_own >= 0));
      chk("gnt_id",  64'(arb_if.gnt_id),  64'(eid));
      chk("preempt", 64'(arb_if.preempt), 64'(m_pre));
      chk("onehot",  64'($countones(arb_if.gnt) <= 1), 64'(1));
`ifdef YUU_COMMON_ARB_STAT_EN
      ecnt = {m_gcnt[3], m_gcnt[2], m_gcnt[1], m_gcnt[0]};
      chk("grant_cnt",   64'(arb_if.grant_cnt),   ecnt);
      chk("preempt_cnt", 64'(arb_if.preempt_cnt), 64'(m_pcnt));
`endif
    end
  end

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst_n       = 1'b0;
    arb_if.done = '0;
    @(negedge clk);
    rst_n       = 1'b1;
    arb_if.req  = r;
  endtask

  initial begin
    logic [3:0] eg;
    arb_if.req  = '0;
    arb_if.done = '0;
    #1;
    rst_n      = 1'b0;
    arb_if.req = 4'b1111;
    repeat (2) @(negedge clk);
    chk("rst_gnt",    64'(arb_if.gnt),     64'(4'b0000));
    chk("rst_gnt_id", 64'(arb_if.gnt_id),  64'(0));
    chk("rst_vld",    64'(arb_if.gnt_vld), 64'(0));
    rst_n      = 1'b1;
    arb_if.req = 4'b0100;
    @(negedge clk);
    chk("first_gnt",    64'(arb_if.gnt),    64'(4'b0100));
    chk("first_gnt_id", 64'(arb_if.gnt_id), 64'(2));
    arb_if.req = 4'b1011;
    @(negedge clk);
    chk("ptr3_gnt", 64'(arb_if.gnt), 64'(4'b1000));

    // Rotation: owner pulses done in its second cycle.
    do_reset(4'b1111);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("rot_id",  64'(arb_if.gnt_id),  64'((c / 2) % 4));
      chk("rot_vld", 64'(arb_if.gnt_vld), 64'(1));
`ifdef YUU_COMMON_ARB_STAT_EN
      if (c == 19) begin
        chk("stat_grant_cnt",   64'(arb_if.grant_cnt),   {16'd2, 16'd2, 16'd3, 16'd3});
        chk("stat_preempt_cnt", 64'(arb_if.preempt_cnt), 64'(0));
      end
`endif
      arb_if.done = (c % 2 == 1) ? 4'(4'b0001 << arb_if.gnt_id) : 4'b0000;
    end

    // Sole requester re-granted back-to-back on done.
    do_reset(4'b0010);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("self_gnt",     64'(arb_if.gnt),     64'(4'b0010));
      chk("self_preempt", 64'(arb_if.preempt), 64'(0));
      arb_if.done = (c % 3 == 2) ? 4'b0010 : 4'b0000;
    end

    // Forced release after MAXH grant cycles.
    do_reset(4'b0001);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      eg = (c < 4) ? 4'b0001 : 4'b1000;
      chk("force_gnt",     64'(arb_if.gnt),     64'(eg));
      chk("force_preempt", 64'(arb_if.preempt), 64'(c == 4));
      if (c == 0) arb_if.req = 4'b1001;
    end

    // Asynchronous reset between clock edges.
    do_reset(4'b0010);
    @(negedge clk);
    chk("async_pre", 64'(arb_if.gnt), 64'(4'b0010));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear",     64'(arb_if.gnt),     64'(4'b0000));
    chk("async_clear_vld", 64'(arb_if.gnt_vld), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("async_regrant",    64'(arb_if.gnt),    64'(4'b0010));
    chk("async_regrant_id", 64'(arb_if.gnt_id), 64'(1));

    // Random traffic; odd segments withhold done so the hold limit and saturation are exercised.
    do_reset(4'b0000);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) arb_if.req[b] = ~arb_if.req[b];
      if ((c / 500) % 2 == 0) arb_if.done = 4'($urandom) & 4'($urandom);
      else                    arb_if.done = 4'b0000;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/yuu_common_rr_arbiter.md
Name: yuu_common_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (bus master port, trace/print channel, config write port) between REQ_NUM requesters.
- Grants are registered and one-hot, and are held until the owner releases them.
- An optional hold limit forces a release when other requesters are waiting.
- Sits between agent-side request logic and the shared resource mux; gnt_id drives the mux select.

Parameters:
- REQ_NUM, 4: number of requesters, 2..16.
- ID_W, $clog2(REQ_NUM): width of gnt_id.
- MAX_HOLD, 16: maximum consecutive grant cycles while others wait. 0 disables the limit.
- CNT_W, 5: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  REQ_NUM  per-requester request level.
- done  input  REQ_NUM  per-requester release pulse; only the current owner's bit is sampled.
- gnt  output  REQ_NUM  one-hot grant, registered.
- gnt_vld  output  1  high when any gnt bit is set.
- gnt_id  output  ID_W  index of the owner; 0 when gnt_vld=0.
- preempt  output  1  one-cycle pulse in the cycle a forced release takes effect.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - gnt=0, gnt_vld=0, gnt_id=0, preempt=0.
  - Priority pointer ptr=0, hold_cnt=0, state=IDLE.
  - Reset asserted mid-grant clears gnt immediately, without waiting for a clock edge.
- States:
  - IDLE: no owner. If |req, the winner is the first set req bit scanning ptr, ptr+1, ... with wrap modulo REQ_NUM. Next cycle: state=GRANT, gnt[w]=1, ptr=(w+1)%REQ_NUM, hold_cnt=0.
  - GRANT: the owner keeps gnt while req[owner]=1 and no release is seen. hold_cnt increments each cycle and saturates at MAX_HOLD.
- Release condition, evaluated in GRANT: req[owner]=0, or done[owner]=1, or forced release.
- Forced release: MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and any other req bit is set.
- On release:
  - Re-arbitrate the same cycle among req with the owner's bit masked, scanning from ptr.
  - If a winner exists: next cycle gnt moves directly to it with no bubble, and hold_cnt=0.
  - If no winner but req[owner]=1 and done[owner]=1: the owner is re-granted (back-to-back) and hold_cnt=0.
  - Otherwise: next cycle gnt=0, state=IDLE.
- Latency:
  - Request to grant: 1 cycle from IDLE.
  - Owner to next owner: 1 cycle after the release is sampled.
- preempt: 1 in the cycle gnt switches because of a forced release, else 0.
- Forced release with no other requester waiting: the owner keeps the grant and hold_cnt saturates. A later request triggers the release on the next evaluation.
- done on a non-owner bit: ignored. done while gnt_vld=0: ignored.
- Simultaneous new requests during a switch: all are resolved by the single ptr scan. No requester waits more than REQ_NUM-1 grants.
- gnt is always zero or one-hot; never more than one bit is set.

Optional Feature:
- Macro: YUU_COMMON_ARB_STAT_EN.
- When defined:
  - Adds output grant_cnt, REQ_NUM x 16 bits: per-requester count of grants issued, wrapping at 2^16.
  - Adds output preempt_cnt, 16 bits: number of forced releases, wrapping.
  - Both counters reset to 0.
- When undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Decomposition:
- yuu_common_pkg:
  - Enum yuu_arb_state_e {IDLE, GRANT}.
  - Function yuu_rr_pick(req, ptr, mask) returning a valid bit and an index; shared with future arbiters.
  - Existing boolean type used for internal flags.
- Sub-module yuu_common_rr_pick: purely combinational masked round-robin picker (req, ptr, mask -> vld, idx). It is instantiated once, in the top. All registers live in the top.

Test Plan:
- Reset/idle: rst_n=0, req=4'b1111 -> gnt=0, gnt_id=0. Release reset with req=4'b0100 -> gnt=4'b0100 and gnt_id=2 one cycle later; ptr becomes 3.
- Rotation: req=4'b1111 held, each owner pulses done after 2 cycles -> grant order 0,1,2,3,0 with no idle cycle between owners.
- Back-to-back self re-grant: only req[1]=1, done[1] pulsed every 3 cycles -> gnt stays 4'b0010 continuously, preempt=0.
- Forced release, MAX_HOLD=4: req[0] held with no done; req[3] rises at cycle 1 -> after 4 grant cycles gnt switches to 4'b1000, with preempt=1 for exactly that cycle.
- Async reset mid-grant: gnt=4'b0010, rst_n falls between clock edges -> gnt=0 before the next edge. After release with req=4'b0010 -> regranted in 1 cycle, ptr starting from 0.
- YUU_COMMON_ARB_STAT_EN: run the rotation scenario for 10 grants -> grant_cnt = {2,2,3,3} (indices 3..0), preempt_cnt=0.
